light_sequencer: RTL

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

---
 rtl/light_sequencer.sv | 81 ++++++++
 1 files changed

// File: rtl/light_sequencer.sv
// Colour sequencer: steps a six-entry RGB code manually (button edges) or automatically (dwell timer).
// Latency: 1 cycle from sampled button rise, dwell expiry or mode change to colour/light/step.
// Backpressure: none; every advance is taken on the edge it is decided.
module light_sequencer #(
    parameter int COMP_W = 8,
    parameter int DWELL  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            mode,
    input  logic                  button,
    input  logic                  dir,
    output logic [3*COMP_W-1:0]   light,
    output logic [2:0]            colour,
    output logic                  step
);

    localparam logic [1:0] MODE_WHITE  = 2'b00;
    localparam logic [1:0] MODE_MANUAL = 2'b01;
    localparam logic [1:0] MODE_AUTO   = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    localparam logic [2:0] COLOUR_FIRST = 3'b001;
    localparam logic [2:0] COLOUR_LAST  = 3'b110;

    logic                  button_q;
    logic [CNT_W-1:0]      dwell_cnt;
    logic                  rise;
    logic                  dwell_done;
    logic                  advance;
    logic [2:0]            colour_nxt;
    logic [3*COMP_W-1:0]   light_nxt;

    always_comb begin
        rise       = button & ~button_q;
        dwell_done = (mode == MODE_AUTO) && (dwell_cnt == CNT_LAST);
        advance    = ((mode == MODE_MANUAL) && rise) || dwell_done;

        colour_nxt = colour;
        if (advance) begin
            if (dir) begin
                colour_nxt = (colour == COLOUR_LAST) ? COLOUR_FIRST : colour + 3'd1;
            end else begin
                colour_nxt = (colour == COLOUR_FIRST) ? COLOUR_LAST : colour - 3'd1;
            end
        end

        // Light follows the colour being loaded this edge so both outputs change together.
        case (mode)
            MODE_WHITE: light_nxt = {3*COMP_W{1'b1}};
            MODE_OFF:   light_nxt = {3*COMP_W{1'b0}};
            default:    light_nxt = {{COMP_W{colour_nxt[2]}},
                                     {COMP_W{colour_nxt[1]}},
                                     {COMP_W{colour_nxt[0]}}};
        endcase
    end

    always_ff @(posedge clk) begin
        // button_q keeps tracking during reset so a held button cannot fake an edge on release.
        button_q <= button;
        if (rst) begin
            colour    <= COLOUR_FIRST;
            light     <= {3*COMP_W{1'b1}};
            step      <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            colour <= colour_nxt;
            light  <= light_nxt;
            step   <= advance;
            if (mode != MODE_AUTO || dwell_done) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + CNT_W'(1);
            end
        end
    end

endmodule
